// File: rtl/ps2_keys_pkg.sv
// Scancodes, direction indices and decoder state encoding shared by the PS/2 movement decoder.
// Lookup helpers map a scancode to a one-hot direction vector and return zero for any other code.
package ps2_keys_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam int DIR_LEFT  = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_DOWN  = 3;
    localparam int NUM_DIRS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } dec_state_t;

    function automatic logic [NUM_DIRS-1:0] arrow_onehot(input logic [7:0] code);
        logic [NUM_DIRS-1:0] dir;
        dir = '0;
        case (code)
            SC_LEFT:  dir[DIR_LEFT]  = 1'b1;
            SC_RIGHT: dir[DIR_RIGHT] = 1'b1;
            SC_UP:    dir[DIR_UP]    = 1'b1;
            SC_DOWN:  dir[DIR_DOWN]  = 1'b1;
            default:  dir = '0;
        endcase
        return dir;
    endfunction

    function automatic logic [NUM_DIRS-1:0] wasd_onehot(input logic [7:0] code);
        logic [NUM_DIRS-1:0] dir;
        dir = '0;
        case (code)
            SC_A:    dir[DIR_LEFT]  = 1'b1;
            SC_D:    dir[DIR_RIGHT] = 1'b1;
            SC_W:    dir[DIR_UP]    = 1'b1;
            SC_S:    dir[DIR_DOWN]  = 1'b1;
            default: dir = '0;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/move_repeat_timer.sv
// Per-direction step generator: one pulse on the held level's rising edge, then auto-repeat
// pulses REPEAT_DELAY cycles later and every REPEAT_PERIOD cycles after that.
module move_repeat_timer #(
    parameter int          CNT_W         = 24,
    parameter int unsigned REPEAT_DELAY  = 12500000,
    parameter int unsigned REPEAT_PERIOD = 2500000
) (
    input  logic clock,
    input  logic resetn,
    input  logic held,
    output logic step
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    generate
        if (REPEAT_DELAY < 1 || 64'(REPEAT_DELAY) > CNT_MAX) begin : g_bad_delay
            $error("move_repeat_timer: REPEAT_DELAY must be in 1..2**CNT_W-1");
        end
        if (REPEAT_PERIOD < 1 || 64'(REPEAT_PERIOD) > CNT_MAX) begin : g_bad_period
            $error("move_repeat_timer: REPEAT_PERIOD must be in 1..2**CNT_W-1");
        end
    endgenerate

    // The pulse fires on the cycle the count reads zero, so loading N-1 spaces pulses exactly N cycles apart.
    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             held_q;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             expire;

    assign rise   = held & ~held_q;
    assign expire = held & held_q & (cnt == '0);
    assign step   = rise | expire;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            held_q <= 1'b0;
            cnt    <= '0;
        end else begin
            held_q <= held;
            if (!held) begin
                cnt <= '0;
            end else if (rise) begin
                cnt <= DELAY_LD;
            end else if (expire) begin
                cnt <= PERIOD_LD;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// Turns the PS/2 scancode byte stream into held arrow-key levels and rate-limited step pulses.
//   state   | meaning
//   IDLE    | waiting for a prefix or a non-extended (WASD) make code
//   E0      | extended prefix seen, next byte is an arrow make or a break prefix
//   F0      | break prefix seen, next byte is a WASD break code
//   E0F0    | extended break prefix seen, next byte is an arrow break code
module ps2_move_decoder
    import ps2_keys_pkg::*;
#(
    parameter bit          ENABLE_WASD    = 1'b1,
    parameter int          CNT_W          = 24,
    parameter int unsigned REPEAT_DELAY   = 12500000,
    parameter int unsigned REPEAT_PERIOD  = 2500000,
    parameter int unsigned PREFIX_TIMEOUT = 5000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_valid,
    input  logic [7:0] key_data,
    output logic       moveleft,
    output logic       moveright,
    output logic       moveup,
    output logic       movedown,
    output logic       step_left,
    output logic       step_right,
    output logic       step_up,
    output logic       step_down
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    generate
        if (PREFIX_TIMEOUT < 1 || 64'(PREFIX_TIMEOUT) > CNT_MAX) begin : g_bad_timeout
            $error("ps2_move_decoder: PREFIX_TIMEOUT must be in 1..2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] PFX_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_state_t          state;
    dec_state_t          state_nxt;
    logic [CNT_W-1:0]    pfx_cnt;
    logic                pfx_expire;
    logic [NUM_DIRS-1:0] arrow_dir;
    logic [NUM_DIRS-1:0] wasd_dir;
    logic [NUM_DIRS-1:0] make_vec;
    logic [NUM_DIRS-1:0] brk_vec;
    logic [NUM_DIRS-1:0] held;
    logic [NUM_DIRS-1:0] raw_step;

    assign arrow_dir  = arrow_onehot(key_data);
    assign wasd_dir   = ENABLE_WASD ? wasd_onehot(key_data) : '0;
    assign pfx_expire = (state != ST_IDLE) && !key_valid && (pfx_cnt == PFX_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        make_vec  = '0;
        brk_vec   = '0;
        if (key_valid) begin
            case (state)
                ST_IDLE: begin
                    if (key_data == SC_EXT) begin
                        state_nxt = ST_E0;
                    end else if (key_data == SC_BREAK) begin
                        state_nxt = ST_F0;
                    end else begin
                        make_vec = wasd_dir;
                    end
                end
                ST_E0: begin
                    if (key_data == SC_BREAK) begin
                        state_nxt = ST_E0F0;
                    end else if (key_data != SC_EXT) begin
                        make_vec  = arrow_dir;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_F0: begin
                    if (key_data != SC_BREAK) begin
                        brk_vec   = wasd_dir;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_E0F0: begin
                    brk_vec   = arrow_dir;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (pfx_expire) begin
            state_nxt = ST_IDLE;
        end
    end

    // Only counts while a prefix is pending; any byte restarts the wait.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pfx_cnt <= '0;
        end else if (key_valid || state == ST_IDLE || pfx_expire) begin
            pfx_cnt <= '0;
        end else begin
            pfx_cnt <= pfx_cnt + CNT_ONE;
        end
    end

    // Arrow and letter for one direction share a bit, so the first break releases it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            held <= '0;
        end else begin
            held <= (held | make_vec) & ~brk_vec;
        end
    end

    generate
        for (genvar d = 0; d < NUM_DIRS; d++) begin : g_timer
            move_repeat_timer #(
                .CNT_W         (CNT_W),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_timer (
                .clock  (clock),
                .resetn (resetn),
                .held   (held[d]),
                .step   (raw_step[d])
            );
        end
    endgenerate

    assign moveleft  = held[DIR_LEFT];
    assign moveright = held[DIR_RIGHT];
    assign moveup    = held[DIR_UP];
    assign movedown  = held[DIR_DOWN];

    // Opposing keys cancel steps on their axis; timers keep running underneath.
    assign step_left  = raw_step[DIR_LEFT]  & ~held[DIR_RIGHT];
    assign step_right = raw_step[DIR_RIGHT] & ~held[DIR_LEFT];
    assign step_up    = raw_step[DIR_UP]    & ~held[DIR_DOWN];
    assign step_down  = raw_step[DIR_DOWN]  & ~held[DIR_UP];

endmodule
